// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
// The bus FSM states and access-size encodings live here.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_BYTE = 2'd0;
    localparam logic [1:0] SEL_HALF = 2'd1;
    localparam logic [1:0] SEL_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_timeout.sv
// Bus acknowledge watchdog: down-counter loaded at grant, expires on the
// TIMEOUT-th strobe cycle without an ack. TIMEOUT of 0 never expires.
module mem_bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_busy,
    input  logic i_ack,
    output logic o_expire
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= LOAD;
        end else if (i_busy && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // An ack in the expiry cycle takes precedence over the abort.
    assign o_expire = (TIMEOUT != 0) && i_busy && !i_ack && (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one strobe/ack memory bus between the fetch and data ports.
// Data has priority; a streak limit guarantees fetch progress.
//
//   state  | meaning
//   IDLE   | choose an owner from the pending requests
//   BUSY_I | fetch transaction on the bus, waiting for ack or timeout
//   BUSY_D | data transaction on the bus, waiting for ack or timeout
//   DONE   | turnaround cycle carrying the owner's valid/err pulse
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_rd_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_valid_o,
    output logic        inst_err_o,
    input  logic        data_rd_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_data_i,
    input  logic [1:0]  data_sel_i,
    output logic [31:0] data_data_o,
    output logic        data_valid_o,
    output logic        data_err_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic [1:0]  bus_sel_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    localparam int SW = (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

    state_t        r_state;
    state_t        w_next_state;
    logic [SW-1:0] r_streak;
    logic          r_inst_valid;
    logic          r_inst_err;
    logic          r_data_valid;
    logic          r_data_err;
    logic          w_data_req;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_done_ok;
    logic          w_done_err;
    logic          w_busy;
    logic          w_expire;

    assign w_data_req = data_rd_i | data_we_i;
    assign w_busy     = (r_state == BUSY_I) || (r_state == BUSY_D);

    mem_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_grant_d | w_grant_i),
        .i_busy   (w_busy),
        .i_ack    (bus_ack_i),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins unless fetch has waited out a full data streak.
                if (w_data_req && !(inst_rd_i && (r_streak == STREAK_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (inst_rd_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus_ack_i) begin
                    w_done_ok    = 1'b1;
                    w_next_state = DONE;
                end else if (w_expire) begin
                    w_done_err   = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak     <= '0;
            bus_stb_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_sel_o    <= SEL_BYTE;
            inst_data_o  <= '0;
            data_data_o  <= '0;
            r_inst_valid <= 1'b0;
            r_inst_err   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_err   <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_inst_err   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_err   <= 1'b0;

            if (w_grant_d) begin
                bus_stb_o  <= 1'b1;
                bus_we_o   <= data_we_i;
                bus_addr_o <= data_addr_i;
                bus_data_o <= data_data_i;
                bus_sel_o  <= data_sel_i;
                // Only grants made while fetch waits count toward the streak.
                if (!inst_rd_i) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if (w_grant_i) begin
                bus_stb_o  <= 1'b1;
                bus_we_o   <= 1'b0;
                bus_addr_o <= inst_addr_i;
                bus_data_o <= '0;
                bus_sel_o  <= SEL_WORD;
                r_streak   <= '0;
            end

            if (w_done_ok || w_done_err) begin
                bus_stb_o <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_inst_valid <= 1'b1;
                    r_inst_err   <= w_done_err;
                    if (w_done_ok) begin
                        inst_data_o <= bus_data_i;
                    end
                end else begin
                    r_data_valid <= 1'b1;
                    r_data_err   <= w_done_err;
                    if (w_done_ok && !bus_we_o) begin
                        data_data_o <= bus_data_i;
                    end
                end
            end
        end
    end

    // A requester that withdrew before DONE gets no completion pulse.
    assign inst_valid_o = r_inst_valid & inst_rd_i;
    assign inst_err_o   = r_inst_err & inst_rd_i;
    assign data_valid_o = r_data_valid & w_data_req;
    assign data_err_o   = r_data_err & w_data_req;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios followed by
// randomized concurrent fetch/data traffic against a transaction-level model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int STREAK = 4;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_rd_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_valid_o;
    logic        inst_err_o;
    logic        data_rd_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_data_i;
    logic [1:0]  data_sel_i;
    logic [31:0] data_data_o;
    logic        data_valid_o;
    logic        data_err_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [1:0]  bus_sel_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    mem_bus_arbiter #(
        .DATA_STREAK_MAX (STREAK),
        .TIMEOUT         (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_rd_i    (inst_rd_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_valid_o (inst_valid_o),
        .inst_err_o   (inst_err_o),
        .data_rd_i    (data_rd_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_data_i  (data_data_i),
        .data_sel_i   (data_sel_i),
        .data_data_o  (data_data_o),
        .data_valid_o (data_valid_o),
        .data_err_o   (data_err_o),
        .bus_stb_o    (bus_stb_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_sel_o    (bus_sel_o),
        .bus_data_i   (bus_data_i),
        .bus_ack_i    (bus_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q_inst[$];
    exp_t        q_data[$];
    int          grant_log[$];
    logic [31:0] prev_inst = '0;
    logic [31:0] prev_data = '0;
    bit          slave_auto = 1'b0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Addresses with bits [15:12] all ones model an unmapped region that never acks.
    function automatic logic is_dead(input logic [31:0] a);
        return a[15:12] == 4'hF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input int exp[$]);
        int act;
        check({name, "_count"}, 64'(grant_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < grant_log.size()) ? grant_log[i] : -1;
            check($sformatf("%s_%0d", name, i), 64'(act), 64'(exp[i]));
        end
    endtask

    task automatic check_reset_state();
        check("reset_ctl", 64'({bus_stb_o, bus_we_o, bus_sel_o, inst_valid_o, inst_err_o,
                                data_valid_o, data_err_o}), 64'd0);
        check("reset_bus", {bus_addr_o, bus_data_o}, 64'd0);
        check("reset_rdata", {inst_data_o, data_data_o}, 64'd0);
    endtask

    task automatic fetch_req(input logic [31:0] a);
        exp_t e;
        int   n;
        e.err  = is_dead(a);
        e.data = is_dead(a) ? prev_inst : rd_val(a);
        prev_inst = e.data;
        q_inst.push_back(e);
        inst_addr_i = a;
        inst_rd_i   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid_o && n < 300);
        check("fetch_completed", 64'(inst_valid_o), 64'd1);
        @(posedge clk); #1;
        inst_rd_i = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sel);
        exp_t e;
        int   n;
        e.err  = is_dead(a);
        e.data = (we || is_dead(a)) ? prev_data : rd_val(a);
        prev_data = e.data;
        q_data.push_back(e);
        data_addr_i = a;
        data_data_i = wd;
        data_sel_i  = sel;
        data_we_i   = we;
        data_rd_i   = !we;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_valid_o && n < 300);
        check("data_completed", 64'(data_valid_o), 64'd1);
        @(posedge clk); #1;
        data_rd_i = 1'b0;
        data_we_i = 1'b0;
    endtask

    // Data access against a hand-driven bus; ack_at==0 means the bus never answers.
    task automatic manual_data(input logic we, input logic [31:0] a, input logic [31:0] rdata,
                               input int ack_at, input string tag);
        exp_t e;
        int   n;
        int   n_hi;
        e.err  = (ack_at == 0);
        e.data = (we || ack_at == 0) ? prev_data : rdata;
        prev_data = e.data;
        q_data.push_back(e);
        bus_data_i  = rdata;
        data_addr_i = a;
        data_data_i = 32'hDEAD_BEEF;
        data_sel_i  = SEL_WORD;
        data_we_i   = we;
        data_rd_i   = !we;
        n    = 0;
        n_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus_stb_o) n_hi++;
            bus_ack_i = (ack_at != 0) && bus_stb_o && (n_hi == ack_at);
        end while (!data_valid_o && n < 60);
        check({tag, "_done"}, 64'(data_valid_o), 64'd1);
        check({tag, "_stb_cycles"}, 64'(n_hi), 64'(TMO));
        check({tag, "_stb_dropped"}, 64'(bus_stb_o), 64'd0);
        @(posedge clk); #1;
        data_rd_i = 1'b0;
        data_we_i = 1'b0;
    endtask

    // Bus slave: random 0..3 cycle ack delay, never acks the unmapped region.
    initial begin : slave
        int wait_n;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (slave_auto) begin
                if (bus_stb_o && !is_dead(bus_addr_o)) begin
                    if (wait_n == 0) begin
                        bus_ack_i  = 1'b1;
                        bus_data_i = bus_we_o ? $urandom : rd_val(bus_addr_o);
                    end else begin
                        wait_n--;
                        bus_ack_i = 1'b0;
                    end
                end else begin
                    bus_ack_i = 1'b0;
                    wait_n    = $urandom_range(0, 3);
                end
            end
        end
    end

    // Monitor: completion scoreboard plus arbitration-rule check at every strobe rise.
    initial begin : monitor
        exp_t        e;
        logic        prev_stb;
        int          low_cnt;
        int          streak_m;
        int          act_owner;
        int          exp_owner;
        logic        dmatch;
        logic        imatch;
        logic        ir_d1, dr_d1, dw_d1;
        logic [31:0] ia_d1, da_d1, dd_d1;
        logic [1:0]  ds_d1;
        prev_stb = 1'b0;
        low_cnt  = 10;
        streak_m = 0;
        ir_d1 = 1'b0; dr_d1 = 1'b0; dw_d1 = 1'b0;
        ia_d1 = '0; da_d1 = '0; dd_d1 = '0; ds_d1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stb = 1'b0;
                low_cnt  = 10;
                streak_m = 0;
                ir_d1 = 1'b0; dr_d1 = 1'b0; dw_d1 = 1'b0;
                continue;
            end
            if (inst_valid_o) begin
                check("inst_pulse_expected", 64'(q_inst.size() > 0), 64'd1);
                if (q_inst.size() > 0) begin
                    e = q_inst.pop_front();
                    check("inst_data", 64'(inst_data_o), 64'(e.data));
                    check("inst_err", 64'(inst_err_o), 64'(e.err));
                end
            end
            if (data_valid_o) begin
                check("data_pulse_expected", 64'(q_data.size() > 0), 64'd1);
                if (q_data.size() > 0) begin
                    e = q_data.pop_front();
                    check("data_data", 64'(data_data_o), 64'(e.data));
                    check("data_err", 64'(data_err_o), 64'(e.err));
                end
            end
            if (bus_stb_o && !prev_stb) begin
                dmatch = (dr_d1 || dw_d1) && (bus_addr_o == da_d1) && (bus_we_o == dw_d1);
                imatch = ir_d1 && (bus_addr_o == ia_d1) && !bus_we_o;
                act_owner = dmatch ? 1 : (imatch ? 0 : 2);
                exp_owner = ((dr_d1 || dw_d1) && !(ir_d1 && streak_m == STREAK)) ? 1 : 0;
                grant_log.push_back(act_owner);
                check("grant_owner", 64'(act_owner), 64'(exp_owner));
                check("strobe_spacing", 64'(low_cnt >= 2), 64'd1);
                if (act_owner == 1) begin
                    check("bus_sel", 64'(bus_sel_o), 64'(ds_d1));
                    if (dw_d1) check("bus_wdata", 64'(bus_data_o), 64'(dd_d1));
                end
                if (exp_owner == 1 && ir_d1) streak_m = (streak_m < STREAK) ? streak_m + 1 : STREAK;
                else streak_m = 0;
            end
            low_cnt  = bus_stb_o ? 0 : low_cnt + 1;
            prev_stb = bus_stb_o;
            ir_d1 = inst_rd_i;
            ia_d1 = inst_addr_i;
            dr_d1 = data_rd_i;
            dw_d1 = data_we_i;
            da_d1 = data_addr_i;
            dd_d1 = data_data_i;
            ds_d1 = data_sel_i;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          n;
        logic [31:0] r;
        rst = 1'b1;
        inst_rd_i = 1'b0; inst_addr_i = '0;
        data_rd_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_data_i = '0; data_sel_i = '0;
        bus_data_i = '0; bus_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch only: strobe one cycle after request, ack two cycles after strobe.
        q_inst.push_back('{err: 1'b0, data: 32'h2408_0005});
        prev_inst = 32'h2408_0005;
        inst_addr_i = 32'h0000_0040;
        inst_rd_i   = 1'b1;
        @(negedge clk);
        check("fetch_stb_not_yet", 64'(bus_stb_o), 64'd0);
        @(negedge clk);
        check("fetch_stb_rise", 64'(bus_stb_o), 64'd1);
        check("fetch_bus_addr", 64'(bus_addr_o), 64'h40);
        @(negedge clk);
        check("fetch_no_early_valid", 64'(inst_valid_o), 64'd0);
        @(negedge clk);
        bus_data_i = 32'h2408_0005;
        bus_ack_i  = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        check("fetch_valid_pulse", 64'(inst_valid_o), 64'd1);
        check("fetch_data_pulse_clear", 64'(data_valid_o), 64'd0);
        @(posedge clk); #1;
        inst_rd_i = 1'b0;

        // Contention: data first, then fetch.
        slave_auto = 1'b1;
        grant_log.delete();
        fork
            fetch_req(32'h0000_0044);
            data_req(1'b0, 32'h0000_0100, 32'h0, SEL_WORD);
        join
        check_log("contention", '{1, 0});

        // Starvation: continuous data traffic with a pending fetch.
        grant_log.delete();
        fork
            fetch_req(32'h0000_0048);
            begin
                for (int k = 0; k < 6; k++) data_req(1'b0, 32'h0000_0104 + 32'(k * 4), 32'h0, SEL_WORD);
            end
        join
        check_log("starvation", '{1, 1, 1, 1, 0, 1, 1});

        // Timeout on a write, then an ack landing in the final allowed cycle.
        slave_auto = 1'b0;
        bus_ack_i  = 1'b0;
        @(posedge clk); #1;
        manual_data(1'b1, 32'h0000_0200, 32'h0, 0, "timeout");
        manual_data(1'b0, 32'h0000_0204, 32'hCAFE_0008, TMO, "ack_at_limit");

        // Flush: fetch withdrawn mid-flight, transaction still completes silently.
        inst_addr_i = 32'h0000_0080;
        inst_rd_i   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_stb_o && n < 20);
        check("flush_stb_seen", 64'(bus_stb_o), 64'd1);
        @(posedge clk); #1;
        inst_rd_i = 1'b0;
        @(negedge clk);
        bus_data_i = 32'h1234_5678;
        bus_ack_i  = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0;
        check("flush_no_pulse", 64'({inst_valid_o, inst_err_o}), 64'd0);
        check("flush_data_captured", 64'(inst_data_o), 64'h1234_5678);
        prev_inst = 32'h1234_5678;
        @(negedge clk);
        check("flush_no_late_pulse", 64'(inst_valid_o), 64'd0);
        @(posedge clk); #1;
        slave_auto = 1'b1;
        data_req(1'b0, 32'h0000_0108, 32'h0, SEL_HALF);

        // Reset in the middle of a data transaction.
        slave_auto = 1'b0;
        bus_ack_i  = 1'b0;
        data_addr_i = 32'h0000_0300;
        data_rd_i   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_stb_o && n < 20);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_stb", 64'(bus_stb_o), 64'd0);
        data_rd_i = 1'b0;
        check_reset_state();
        q_inst.delete();
        q_data.delete();
        prev_inst = '0;
        prev_data = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        slave_auto = 1'b1;
        fetch_req(32'h0000_008C);

        // Randomized concurrent traffic.
        fork
            begin
                logic [31:0] fa;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    fa = $urandom;
                    fetch_req({16'h0000, fa[15:2], 2'b00});
                end
            end
            begin
                logic [31:0] da;
                logic [1:0]  ds;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    da = $urandom;
                    ds = 2'($urandom_range(0, 2));
                    data_req(da[16], {16'h1000, da[15:0]}, $urandom, ds);
                end
            end
        join
        r = 32'(q_inst.size() + q_data.size());
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(r), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
